// File: rtl/spi_cfg_master.sv
// spi_cfg_master: SPI mode-0 master serializing 12-bit {addr,data} register writes
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_addr/req_data request handshake;
//    busy (frame or gap), done (one-cycle frame-end pulse), rx_data (miso bits of last frame);
//    sclk/cs_n/mosi/miso SPI pins, all outputs registered.
module spi_cfg_master #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_addr,
   input  logic [7:0]  req_data,
   output logic        busy,
   output logic        done,
   output logic [11:0] rx_data,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   input  logic        miso
);
   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
   localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LD = 8'(CS_GAP - 1);
   state_t      r_state;
   logic [7:0]  r_div;
   logic [3:0]  r_bit;
   logic [11:0] r_shift;
   logic [11:0] r_rx;
   logic        r_ready, r_busy, r_done, r_sclk, r_cs_n, r_mosi;
   logic        w_tick;
   assign w_tick    = r_div == 8'd0;
   assign req_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign rx_data   = r_rx;
   assign sclk      = r_sclk;
   assign cs_n      = r_cs_n;
   assign mosi      = r_mosi;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_div   <= 8'd0;
         r_bit   <= 4'd0;
         r_shift <= 12'd0;
         r_rx    <= 12'd0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_mosi  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_div  <= r_div - 8'd1;
         case (r_state)
            IDLE: if (req_valid) begin
               r_state <= SETUP;
               r_ready <= 1'b0;
               r_busy  <= 1'b1;
               r_cs_n  <= 1'b0;
               r_mosi  <= req_addr[3];
               r_shift <= {req_addr, req_data};
               r_bit   <= 4'd11;
               r_div   <= DIV_LD;
            end
            // miso is captured on the same clock that raises sclk
            SETUP, LOW: if (w_tick) begin
               r_state <= HIGH;
               r_sclk  <= 1'b1;
               r_rx    <= {r_rx[10:0], miso};
               r_div   <= DIV_LD;
            end
            // next mosi bit is launched together with the falling sclk
            HIGH: if (w_tick) begin
               r_sclk <= 1'b0;
               r_div  <= DIV_LD;
               if (r_bit == 4'd0) r_state <= HOLD;
               else begin
                  r_state <= LOW;
                  r_bit   <= r_bit - 4'd1;
                  r_shift <= {r_shift[10:0], 1'b0};
                  r_mosi  <= r_shift[10];
               end
            end
            HOLD: if (w_tick) begin
               r_state <= GAP;
               r_cs_n  <= 1'b1;
               r_mosi  <= 1'b0;
               r_done  <= 1'b1;
               r_div   <= GAP_LD;
            end
            GAP: if (w_tick) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master: directed bench for spi_cfg_master at CLK_DIV=4 and CLK_DIV=2
module tb_spi_cfg_master;
   typedef struct {
      logic        s;
      logic [3:0]  a;
      logic [7:0]  d;
      logic        lp;
      int          div;
      logic [11:0] rx;
   } vec_t;
   logic        clk = 1'b0, reset = 1'b1, rv = 1'b0, sel = 1'b0, loop = 1'b0;
   logic [3:0]  ra = 4'd0;
   logic [7:0]  rd = 8'd0;
   logic        rdy0, busy0, done0, sclk0, cs0, mosi0, miso0;
   logic        rdy1, busy1, done1, sclk1, cs1, mosi1, miso1;
   logic [11:0] rx0, rx1;
   logic        w_rdy, w_busy, w_done, w_sclk, w_cs, w_mosi;
   logic [11:0] w_rx;
   int          n_chk = 0, n_fail = 0, cyc = 0, t_done = 0, t_cs0 = 0;
   int          td, k, rises, dn;
   logic        ps;
   vec_t        tbl[5];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign miso0 = loop ? mosi0 : ~mosi0;
   assign miso1 = loop ? mosi1 : ~mosi1;
   assign w_rdy  = sel ? rdy1  : rdy0;
   assign w_busy = sel ? busy1 : busy0;
   assign w_done = sel ? done1 : done0;
   assign w_sclk = sel ? sclk1 : sclk0;
   assign w_cs   = sel ? cs1   : cs0;
   assign w_mosi = sel ? mosi1 : mosi0;
   assign w_rx   = sel ? rx1   : rx0;
   spi_cfg_master #(.CLK_DIV(4), .CS_GAP(2)) u0 (
      .clk(clk), .reset(reset), .req_valid(rv & ~sel), .req_ready(rdy0),
      .req_addr(ra), .req_data(rd), .busy(busy0), .done(done0), .rx_data(rx0),
      .sclk(sclk0), .cs_n(cs0), .mosi(mosi0), .miso(miso0));
   spi_cfg_master #(.CLK_DIV(2), .CS_GAP(2)) u1 (
      .clk(clk), .reset(reset), .req_valid(rv & sel), .req_ready(rdy1),
      .req_addr(ra), .req_data(rd), .busy(busy1), .done(done1), .rx_data(rx1),
      .sclk(sclk1), .cs_n(cs1), .mosi(mosi1), .miso(miso1));
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic do_frame(input logic s, input logic [3:0] a, input logic [7:0] d,
                           input logic lp, input int div, input logic [11:0] exp_rx,
                           input logic hold, input logic [3:0] na, input logic [7:0] nd);
      int n = 0, r = 0, hi = 0, lo = 0, bad = 0, gl = 0, csl = 0;
      logic [11:0] bits = 12'd0;
      logic p_s = 1'b0, p_m, p_c = 1'b0;
      sel = s; loop = lp; ra = a; rd = d; rv = 1'b1;
      while (!w_rdy && n < 400) begin @(negedge clk); n++; end
      chk("ready_wait", int'(n < 400), 1);
      @(negedge clk);
      if (hold) begin ra = na; rd = nd; end else rv = 1'b0;
      chk("cs_start", w_cs, 0);
      chk("busy_start", w_busy, 1);
      t_cs0 = cyc;
      p_m = w_mosi;
      n = 0;
      while (!w_done && n < 2000) begin
         if (!w_cs) csl++;
         if (w_sclk && !p_s) begin
            r++;
            bits = {bits[10:0], w_mosi};
            if (r > 1 && lo != div) bad++;
            if (w_mosi !== p_m) gl++;
            hi = 1;
         end else if (w_sclk) begin
            hi++;
            if (w_mosi !== p_m) gl++;
         end else if (p_s) begin
            if (hi != div) bad++;
            lo = 1;
         end else lo++;
         p_s = w_sclk; p_m = w_mosi; p_c = w_cs;
         @(negedge clk);
         n++;
      end
      chk("done_seen", w_done, 1);
      chk("done_cs_rise", {p_c, w_cs}, 2'b01);
      chk("cs_low_len", csl, 25 * div);
      chk("sclk_rises", r, 12);
      chk("mosi_bits", bits, {a, d});
      chk("phase_len", bad, 0);
      chk("mosi_while_high", gl, 0);
      chk("rx_at_done", w_rx, exp_rx);
      t_done = cyc;
      @(negedge clk);
      chk("done_width", w_done, 0);
      chk("gap_ready1", w_rdy, 0);
      @(negedge clk);
      chk("gap_ready2", w_rdy, 1);
      chk("busy_end", w_busy, 0);
   endtask
   initial begin
      tbl[0] = '{1'b0, 4'h3, 8'hA5, 1'b0, 4, 12'hC5A};
      tbl[1] = '{1'b0, 4'hC, 8'h3E, 1'b1, 4, 12'hC3E};
      tbl[2] = '{1'b1, 4'h5, 8'h7F, 1'b1, 2, 12'h57F};
      tbl[3] = '{1'b1, 4'h0, 8'h00, 1'b0, 2, 12'hFFF};
      tbl[4] = '{1'b0, 4'hF, 8'hFF, 1'b0, 4, 12'h000};
      rv = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", w_rdy, 1);
      chk("rst_busy", w_busy, 0);
      chk("rst_done", w_done, 0);
      chk("rst_rx", w_rx, 0);
      chk("rst_sclk", w_sclk, 0);
      chk("rst_cs", w_cs, 1);
      chk("rst_mosi", w_mosi, 0);
      reset = 1'b0; rv = 1'b0;
      @(negedge clk);
      chk("valid_in_reset_cs", w_cs, 1);
      chk("valid_in_reset_busy", w_busy, 0);
      for (int i = 0; i < 5; i++)
         do_frame(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].lp, tbl[i].div, tbl[i].rx, 1'b0, 4'h0, 8'h00);
      do_frame(1'b0, 4'h1, 8'h11, 1'b1, 4, 12'h111, 1'b1, 4'h2, 8'h22);
      td = t_done;
      do_frame(1'b0, 4'h2, 8'h22, 1'b1, 4, 12'h222, 1'b0, 4'h0, 8'h00);
      chk("queued_cs_high", t_cs0 - td, 3);
      sel = 1'b0; loop = 1'b1; ra = 4'h6; rd = 8'h9C; rv = 1'b1;
      @(negedge clk);
      rv = 1'b0;
      rises = 0; k = 0; ps = 1'b0;
      while (rises < 6 && k < 500) begin
         @(negedge clk);
         k++;
         if (w_sclk && !ps) rises++;
         ps = w_sclk;
      end
      chk("reset_reach_rise6", rises, 6);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_cs", w_cs, 1);
      chk("midrst_sclk", w_sclk, 0);
      chk("midrst_mosi", w_mosi, 0);
      chk("midrst_rx", w_rx, 0);
      chk("midrst_ready", w_rdy, 1);
      chk("midrst_busy", w_busy, 0);
      reset = 1'b0;
      dn = 0;
      repeat (150) begin
         @(negedge clk);
         if (w_done) dn++;
      end
      chk("midrst_no_done", dn, 0);
      do_frame(1'b0, 4'h6, 8'h9C, 1'b1, 4, 12'h69C, 1'b0, 4'h0, 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
